// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: N-way grant-holding arbiter.
// Fixed (highest index) or round-robin priority, hold timeout.
module req_priority_arbiter #(
  parameter int N        = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            rel,
  input  logic            rr_mode,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int CNT_W =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST =
    (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit TO_EN = (MAX_HOLD != 0);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic               r_gnt_valid;
  logic               r_timeout;
  logic [ID_W-1:0]    r_last_id;
  logic [CNT_W-1:0]   r_hold_cnt;

  logic [ID_W-1:0]    w_fix_id;
  logic [ID_W-1:0]    w_rr_id;
  logic               w_rr_hit;
  logic [ID_W-1:0]    w_win_id;
  logic               w_drop;
  logic               w_to;
  logic               w_exit;

  // Index probed at step k of the downward search below last_id.
  function automatic logic [ID_W-1:0] rr_idx(
    input logic [ID_W-1:0] last,
    input int              k
  );
    int t;
    t = (int'(last) + 2 * N - 1 - k) % N;
    return ID_W'(t);
  endfunction

  // Winner selection: fixed highest-index or rotating search.
  always_comb begin
    w_fix_id = '0;
    w_rr_id  = '0;
    w_rr_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_fix_id = ID_W'(i);
    end
    for (int k = 0; k < N; k++) begin
      if (!w_rr_hit && req[rr_idx(r_last_id, k)]) begin
        w_rr_hit = 1'b1;
        w_rr_id  = rr_idx(r_last_id, k);
      end
    end
    w_win_id = rr_mode ? w_rr_id : w_fix_id;
  end

  assign w_drop = !req[r_gnt_id];
  assign w_to   = TO_EN &&
                  (r_hold_cnt == CNT_W'(HOLD_LAST));
  assign w_exit = rel || w_drop || w_to;

  // Grant FSM with registered outputs and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_id   <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win_id;
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_last_id   <= w_win_id;
            r_hold_cnt  <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_exit) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_timeout   <= w_to && !rel && !w_drop;
            r_state     <= S_IDLE;
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// tb_req_priority_arbiter: directed vector table plus
// hand sequences for timeout, release races and async reset.
module tb_req_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk;
  int n_pass;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       rr;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tv[$];

  req_priority_arbiter #(
    .N(8), .ID_W(3), .MAX_HOLD(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [7:0] e_gnt,
    input logic [2:0] e_id,
    input logic       e_vld,
    input logic       e_to
  );
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".id"}, 32'(gnt_id), 32'(e_id));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(e_vld));
    chk({tag, ".to"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(
    input logic       r,
    input logic [7:0] q,
    input logic       l,
    input logic       m,
    input logic [7:0] g,
    input logic [2:0] i,
    input logic       v,
    input logic       t
  );
    vec_t x;
    x.rst = r; x.req = q; x.rel = l; x.rr = m;
    x.gnt = g; x.id = i; x.vld = v; x.to = t;
    tv.push_back(x);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    req     = '0;
    rel     = 1'b0;
    rr_mode = 1'b0;

    // idle: no requests
    add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // fixed mode, 0010_0110 -> owner 5
    add(0, 8'h26, 0, 0, 8'h20, 5, 1, 0);
    add(0, 8'h26, 0, 0, 8'h20, 5, 1, 0);
    add(0, 8'h26, 0, 0, 8'h20, 5, 1, 0);
    add(0, 8'h26, 1, 0, 8'h00, 5, 0, 0);
    add(0, 8'h26, 0, 0, 8'h20, 5, 1, 0);
    add(0, 8'h26, 1, 0, 8'h00, 5, 0, 0);
    // round robin 1000_0101 -> 7,2,0,7,2,0
    add(1, 8'h85, 1, 1, 8'h80, 7, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 7, 0, 0);
    add(0, 8'h85, 1, 1, 8'h04, 2, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 2, 0, 0);
    add(0, 8'h85, 1, 1, 8'h01, 0, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 0, 0, 0);
    add(0, 8'h85, 1, 1, 8'h80, 7, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 7, 0, 0);
    add(0, 8'h85, 1, 1, 8'h04, 2, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 2, 0, 0);
    add(0, 8'h85, 1, 1, 8'h01, 0, 1, 0);
    add(0, 8'h85, 1, 1, 8'h00, 0, 0, 0);
    // owner drops request, others ignored
    add(1, 8'h10, 0, 0, 8'h10, 4, 1, 0);
    add(0, 8'h10, 0, 0, 8'h10, 4, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 4, 0, 0);
    add(0, 8'h10, 0, 0, 8'h10, 4, 1, 0);
    add(0, 8'h90, 0, 0, 8'h10, 4, 1, 0);
    add(0, 8'h80, 0, 0, 8'h00, 4, 0, 0);
    add(0, 8'h80, 0, 0, 8'h80, 7, 1, 0);
    // rr_mode flip in BUSY only matters at next IDLE
    add(0, 8'h80, 0, 1, 8'h80, 7, 1, 0);
    add(0, 8'h81, 1, 1, 8'h00, 7, 0, 0);
    add(0, 8'h81, 0, 1, 8'h01, 0, 1, 0);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      req     = tv[i].req;
      rel     = tv[i].rel;
      rr_mode = tv[i].rr;
      step();
      chk_out($sformatf("v%0d", i), tv[i].gnt,
              tv[i].id, tv[i].vld, tv[i].to);
    end

    // hold timeout: 16 cycles granted, pulse, regrant
    rel = 1'b0; rr_mode = 1'b0; req = '0;
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 16; c++) begin
      step();
      chk_out($sformatf("hold%0d", c),
              8'h08, 3'd3, 1'b1, 1'b0);
    end
    step();
    chk_out("to_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    step();
    chk_out("to_regnt", 8'h08, 3'd3, 1'b1, 1'b0);

    // release on the expiry edge: no timeout pulse
    req = '0;
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 16; c++) step();
    chk("race.pre_vld", 32'(gnt_valid), 32'd1);
    rel = 1'b1;
    step();
    chk_out("race", 8'h00, 3'd3, 1'b0, 1'b0);
    rel = 1'b0;
    step();
    chk_out("race_nx", 8'h08, 3'd3, 1'b1, 1'b0);

    // async reset while owner 6 holds the grant
    req = '0;
    do_reset();
    req = 8'h40;
    step();
    step();
    chk_out("ar_pre", 8'h40, 3'd6, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("ar_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    rr_mode = 1'b1;
    req = 8'h41;
    step();
    chk_out("ar_rr", 8'h40, 3'd6, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/req_priority_arbiter.md
Name: req_priority_arbiter

Overview:
- Sequential arbiter that shares one resource among N requesters, using the priority-encoding function of the encoder datapath.
- Fixed-priority mode: highest index wins. Round-robin mode: rotates priority away from the last winner.
- Holds a grant until the owner releases it, drops its request, or a hold-timeout expires.
- Sits in front of any shared bus or port whose owner is chosen by priority encoding.

Parameters:
- N, 8, number of requesters (N >= 2).
- ID_W, 3, grant index width; must equal clog2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector, bit i = requester i
- rel  input  1  owner releases grant (sampled only in BUSY)
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
- gnt  output  N  one-hot grant vector, registered
- gnt_id  output  ID_W  index of current owner, registered
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
Clock and reset:
- One clock: clk. Reset is asynchronous and active-low: rst_n.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE, last_id=0, hold_cnt=0.
- rst_n low at any point, including mid-grant, drops the grant immediately (asynchronously). No pulse on timeout.

FSM, two states:
- IDLE:
  - If |req, the winner is selected combinationally from req. On the next edge: gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, last_id=winner, state=BUSY.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0, stay in IDLE with outputs 0.
- BUSY: leaves to IDLE on the edge where any of these holds:
  - (a) rel=1;
  - (b) req[gnt_id]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On exit: gnt=0, gnt_valid=0, gnt_id keeps its last value, hold_cnt=0.
  - Otherwise hold_cnt increments by 1. It is ID-independent and saturates, never wraps.
- Timeout pulse: timeout=1 for exactly the cycle after the edge where exit cause (c) is taken, and only if neither (a) nor (b) is also true on that edge. Release has precedence over timeout.
- Dead cycle: every grant is followed by at least one IDLE cycle with gnt_valid=0. Back-to-back grants are therefore spaced at least 1 cycle apart.

Winner selection:
- Fixed mode: highest set index of req.
- Round-robin mode: search downward starting at (last_id-1) mod N, wrapping from 0 to N-1; the first set bit wins. The previous winner has lowest priority and wins only if it is the sole requester.
- Since last_id resets to 0, the first RR search order is N-1 down to 0, identical to fixed mode.
- last_id updates on every grant in either mode.

Other rules:
- Changes to req bits other than the owner's during BUSY are ignored.
- rr_mode changes during BUSY take effect at the next IDLE.
- gnt is always one-hot or zero, and gnt_valid == |gnt.
- An X on req in IDLE must not be granted; the bench treats that as an error.

Test Plan:
- Reset then req=8'b0000_0000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- Fixed mode, req=8'b0010_0110 held, rel pulsed 1 cycle after 3 BUSY cycles -> gnt=8'b0010_0000, gnt_id=5; one IDLE cycle; then gnt_id=5 again, never 2 or 1.
- RR mode, req=8'b1000_0101 held, rel pulsed each BUSY cycle -> grant sequence gnt_id=7,2,0,7,2,0 with one dead cycle between grants.
- MAX_HOLD=16, single req[3]=1 held, no rel -> gnt_valid high exactly 16 cycles, timeout=1 on the following cycle, then regrant to 3 after the IDLE cycle.
- Owner drops request: req[4] granted, req[4] deasserted on BUSY cycle 2 -> gnt=0 next edge, timeout stays 0. Same-edge rel and timeout expiry -> timeout stays 0.
- Async reset mid-grant: assert rst_n=0 between clock edges while gnt_id=6 -> gnt, gnt_valid go 0 immediately; after release, the first RR grant with req=8'b0100_0001 gives gnt_id=6 (last_id reset to 0).
